adder_op_sequencer: RTL and testbench

- Clocked controller that sequences the 4-bit adder datapath from the switch/button front panel.
- Debounces Btn0. On each press it captures the two 4-bit operands from the switches and drives them onto the adder.
- Waits a fixed settle time, then latches the 5-bit sum into a stable output register with a done pulse.
- Sits between the board I/O (Sw, Btn0) and the combinational adder instance; the adder becomes a slave of this block.

---
 rtl/adder_op_sequencer_pkg.sv | 18 +
 rtl/adder_op_sequencer_btn_debounce.sv | 62 ++++++
 rtl/adder_op_sequencer.sv | 117 +++++++++++
 tb/tb_adder_op_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_op_sequencer_pkg.sv
// Shared constants for the adder operation sequencer: state encoding,
// datapath widths and default timing parameters.
package adder_op_sequencer_pkg;

  localparam int OPND_W = 4;
  localparam int SUM_W  = 5;

  localparam int DEB_CYCLES_DEF    = 4;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_SETTLE   = 2'd1;
  localparam state_t ST_LATCH    = 2'd2;
  localparam state_t ST_WAIT_REL = 2'd3;

endpackage

// File: rtl/adder_op_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter, clean level
// and a one-cycle press event on each clean rising transition.
module btn_debounce
  import adder_op_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic btn,
  output logic clean,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic             press_evt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             expire_s;

  // The level flips on the DEB_CYCLES-th consecutive cycle of disagreement.
  assign differ_s = sync2_r ^ clean_r;
  assign expire_s = differ_s && (cnt_r == CNT_W'(DEB_CYCLES - 1));

  // Synchronizer, stability counter, clean level and press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      clean_r     <= 1'b0;
      press_evt_r <= 1'b0;
      cnt_r       <= '0;
    end else if (srst) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      clean_r     <= 1'b0;
      press_evt_r <= 1'b0;
      cnt_r       <= '0;
    end else begin
      sync1_r     <= btn;
      sync2_r     <= sync1_r;
      press_evt_r <= expire_s & ~clean_r;
      if (expire_s) begin
        clean_r <= ~clean_r;
        cnt_r   <= '0;
      end else if (differ_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign clean     = clean_r;
  assign press_evt = press_evt_r;

endmodule

// File: rtl/adder_op_sequencer.sv
// Front-panel sequencer for the 4-bit adder: debounced press captures the
// switch operands, waits for the adder to settle, then latches the sum.
// Build option ADDER_ACCUM_EN: operand B is the running total and Ovf is sticky.
module adder_op_sequencer
  import adder_op_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [7:0]        Sw,
  input  logic              Btn0,
  output logic [OPND_W-1:0] Add_A,
  output logic [OPND_W-1:0] Add_B,
  input  logic [SUM_W-1:0]  Add_Sum,
  output logic [SUM_W-1:0]  Output,
  output logic              Busy,
  output logic              Done,
  output logic              Ovf
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t              state_r;
  logic [SCNT_W-1:0]   settle_cnt_r;
  logic [OPND_W-1:0]   add_a_r;
  logic [OPND_W-1:0]   add_b_r;
  logic [SUM_W-1:0]    result_r;
  logic                busy_r;
  logic                done_r;
  logic                ovf_r;
  logic                clean_s;
  logic                press_evt_s;
  logic [OPND_W-1:0]   opnd_b_s;
  logic                ovf_next_s;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn0_deb (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .srst      (1'b0),
    .btn       (Btn0),
    .clean     (clean_s),
    .press_evt (press_evt_s)
  );

`ifdef ADDER_ACCUM_EN
  logic unused_sw_hi_s;
  assign unused_sw_hi_s = ^Sw[7:4];
  assign opnd_b_s       = result_r[OPND_W-1:0];
  assign ovf_next_s     = ovf_r | Add_Sum[SUM_W-1];
`else
  assign opnd_b_s       = Sw[7:4];
  assign ovf_next_s     = Add_Sum[SUM_W-1];
`endif

  // Operation FSM with operand, result and status registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= '0;
      add_a_r      <= '0;
      add_b_r      <= '0;
      result_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (press_evt_s) begin
            add_a_r      <= Sw[3:0];
            add_b_r      <= opnd_b_s;
            busy_r       <= 1'b1;
            settle_cnt_r <= '0;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SCNT_W'(SETTLE_CYCLES - 1)) begin
            state_r <= ST_LATCH;
          end else begin
            settle_cnt_r <= settle_cnt_r + SCNT_W'(1);
          end
        end
        ST_LATCH: begin
          result_r <= Add_Sum;
          ovf_r    <= ovf_next_s;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          // A new operation needs the clean level to drop first.
          if (!clean_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Add_A  = add_a_r;
  assign Add_B  = add_b_r;
  assign Output = result_r;
  assign Busy   = busy_r;
  assign Done   = done_r;
  assign Ovf    = ovf_r;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Directed bench for adder_op_sequencer with a behavioural adder attached.
// Expectations follow ADDER_ACCUM_EN when the macro is defined.
module tb_adder_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn0;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [4:0] add_sum;
  logic [4:0] result;
  logic       busy;
  logic       done;
  logic       ovf;

  int n_checks;
  int n_errors;
  int cyc;
  int done_cnt;
  int busy_cnt;
  int done_at;

  adder_op_sequencer #(
    .DEB_CYCLES    (4),
    .SETTLE_CYCLES (2)
  ) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Sw      (sw),
    .Btn0    (btn0),
    .Add_A   (add_a),
    .Add_B   (add_b),
    .Add_Sum (add_sum),
    .Output  (result),
    .Busy    (busy),
    .Done    (done),
    .Ovf     (ovf)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    cyc      = 0;
    done_cnt = 0;
    busy_cnt = 0;
    done_at  = -1;
  endtask

  // Step n cycles, sampling 1 ns after each rising edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_mon();
    rst_n = 1'b0;
    btn0  = 1'b0;
    sw    = 8'h00;
    run_cycles(3);
    check_val("rst_out", result, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_a", add_a, 0);
    rst_n = 1'b1;
    run_cycles(2);

    // 3-cycle glitches never reach the 4-cycle stability threshold
    clear_mon();
    sw = 8'h9A;
    for (int k = 0; k < 5; k++) begin
      btn0 = 1'b1;
      run_cycles(3);
      btn0 = 1'b0;
      run_cycles(2);
    end
    run_cycles(10);
    check_val("bnc_busy", busy_cnt, 0);
    check_val("bnc_done", done_cnt, 0);
    check_val("bnc_out", result, 0);

`ifndef ADDER_ACCUM_EN
    clear_mon();
    sw   = 8'b1001_1010;
    btn0 = 1'b1;
    run_cycles(20);
    check_val("add_a", add_a, 10);
    check_val("add_b", add_b, 9);
    check_val("add_out", result, 5'b10011);
    check_val("add_ovf", ovf, 1);
    check_val("add_done", done_cnt, 1);
    check_val("add_busy", busy_cnt, 3);
    check_val("add_lat", done_at, 10);
    btn0 = 1'b0;
    run_cycles(10);

    clear_mon();
    sw   = 8'h21;
    btn0 = 1'b1;
    run_cycles(7);
    check_val("sw_busy", busy, 1);
    sw = 8'hFF;
    run_cycles(13);
    check_val("sw_a", add_a, 1);
    check_val("sw_b", add_b, 2);
    check_val("sw_out", result, 5'b00011);
    check_val("sw_ovf", ovf, 0);
    check_val("sw_done", done_cnt, 1);
    clear_mon();
    run_cycles(20);
    check_val("hold_done", done_cnt, 0);
    check_val("hold_busy", busy_cnt, 0);
    check_val("hold_out", result, 5'b00011);
    btn0 = 1'b0;
    run_cycles(10);

    clear_mon();
    sw   = 8'h35;
    btn0 = 1'b1;
    run_cycles(20);
    check_val("rep_out", result, 5'b01000);
    check_val("rep_ovf", ovf, 0);
    check_val("rep_done", done_cnt, 1);
`else
    clear_mon();
    sw   = 8'h09;
    btn0 = 1'b1;
    run_cycles(20);
    check_val("acc1_out", result, 9);
    check_val("acc1_ovf", ovf, 0);
    check_val("acc1_done", done_cnt, 1);
    btn0 = 1'b0;
    run_cycles(10);

    clear_mon();
    btn0 = 1'b1;
    run_cycles(20);
    check_val("acc2_b", add_b, 9);
    check_val("acc2_out", result, 5'b10010);
    check_val("acc2_ovf", ovf, 1);
    btn0 = 1'b0;
    run_cycles(10);

    clear_mon();
    sw   = 8'hF1;
    btn0 = 1'b1;
    run_cycles(20);
    check_val("acc3_b", add_b, 2);
    check_val("acc3_out", result, 5'b00011);
    check_val("acc3_ovf", ovf, 1);
    check_val("acc3_done", done_cnt, 1);
`endif
    btn0 = 1'b0;
    run_cycles(10);

    // Reset asserted while the operation sits in SETTLE
    clear_mon();
    sw   = 8'h77;
    btn0 = 1'b1;
    run_cycles(8);
    check_val("mid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check_val("mid_rst_out", result, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_ovf", ovf, 0);
    btn0 = 1'b0;
    run_cycles(3);
    rst_n = 1'b1;
    clear_mon();
    run_cycles(20);
    check_val("mid_no_done", done_cnt, 0);
    check_val("mid_no_busy", busy_cnt, 0);

    // Button held through reset deassertion is still seen as a press
    rst_n = 1'b0;
    btn0  = 1'b1;
    run_cycles(3);
    rst_n = 1'b1;
    clear_mon();
    run_cycles(20);
    check_val("held_lat", done_at, 10);
    check_val("held_done", done_cnt, 1);
`ifndef ADDER_ACCUM_EN
    check_val("held_out", result, 5'b01110);
`else
    check_val("held_out", result, 5'b00111);
`endif
    check_val("held_ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
